// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Holds FSM states, opcode type and status flag bit positions.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD = 3'd0;
    localparam alu_op_t OP_SUB = 3'd1;
    localparam alu_op_t OP_AND = 3'd2;
    localparam alu_op_t OP_OR  = 3'd3;
    localparam alu_op_t OP_XOR = 3'd4;
    localparam alu_op_t OP_SLL = 3'd5;
    localparam alu_op_t OP_SRL = 3'd6;
    localparam alu_op_t OP_SLT = 3'd7;

    localparam int STAT_N = 3;
    localparam int STAT_Z = 2;
    localparam int STAT_C = 1;
    localparam int STAT_V = 0;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters.
// Produces a result and {N,Z,C,V} flags.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [Width-1:0] result_o,
    output logic [3:0]       status_o
);

    localparam int ShW = $clog2(Width);

    logic [Width:0] sum;
    logic [Width:0] dif;
    logic           carry;
    logic           ovf;

    assign sum = {1'b0, a_i} + {1'b0, b_i};
    // Subtract as a + ~b + 1 so C means "no borrow".
    assign dif = {1'b0, a_i} + {1'b0, ~b_i} + {{Width{1'b0}}, 1'b1};

    always_comb begin
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                result_o = sum[Width-1:0];
                carry    = sum[Width];
                ovf      = (a_i[Width-1] == b_i[Width-1]) &&
                           (sum[Width-1] != a_i[Width-1]);
            end
            OP_SUB: begin
                result_o = dif[Width-1:0];
                carry    = dif[Width];
                ovf      = (a_i[Width-1] != b_i[Width-1]) &&
                           (dif[Width-1] != a_i[Width-1]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SLL: result_o = a_i << b_i[ShW-1:0];
            OP_SRL: result_o = a_i >> b_i[ShW-1:0];
            OP_SLT: result_o = {{(Width-1){1'b0}},
                                ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end

    always_comb begin
        status_o         = '0;
        status_o[STAT_N] = result_o[Width-1];
        status_o[STAT_Z] = (result_o == '0);
        status_o[STAT_C] = carry;
        status_o[STAT_V] = ovf;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU, one operation in flight.
// IDLE accepts, EXEC computes, RESP holds until consumed.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RoundRobin = 1'b1,
    parameter int DataWidth  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DataWidth-1:0] req0_a,
    input  logic [DataWidth-1:0] req0_b,
    input  logic [2:0]           req0_opcode,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DataWidth-1:0] req1_a,
    input  logic [DataWidth-1:0] req1_b,
    input  logic [2:0]           req1_opcode,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [DataWidth-1:0] rsp0_result,
    output logic [3:0]           rsp0_status,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [DataWidth-1:0] rsp1_result,
    output logic [3:0]           rsp1_status
);

    state_e                      state_q, state_d;
    logic                        owner_q, owner_d;
    logic                        last_q, last_d;
    logic [DataWidth-1:0]        a_q, a_d;
    logic [DataWidth-1:0]        b_q, b_d;
    alu_op_t                     op_q, op_d;
    logic [1:0]                  rv_q, rv_d;
    logic [1:0][DataWidth-1:0]   res_q, res_d;
    logic [1:0][3:0]             st_q, st_d;

    logic                        idle;
    logic                        both;
    logic                        winner;
    logic                        accept;
    logic                        own_rdy;
    logic [DataWidth-1:0]        alu_res;
    logic [3:0]                  alu_st;

    // Gating with rst_n keeps ready low during reset.
    assign idle   = rst_n && (state_q == ST_IDLE);
    assign both   = req0_valid && req1_valid;
    assign winner = RoundRobin ? (both ? ~last_q : req1_valid)
                               : ~req0_valid;
    assign accept = idle && (req0_valid || req1_valid);

    assign req0_ready = idle && !winner && req0_valid;
    assign req1_ready = idle &&  winner && req1_valid;

    assign own_rdy = owner_q ? rsp1_ready : rsp0_ready;

    alu_arbiter_alu #(
        .Width (DataWidth)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_res),
        .status_o (alu_st)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rv_d    = rv_q;
        res_d   = res_q;
        st_d    = st_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = winner;
                    last_d  = winner;
                    a_d     = winner ? req1_a : req0_a;
                    b_d     = winner ? req1_b : req0_b;
                    op_d    = winner ? req1_opcode : req0_opcode;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d[owner_q] = alu_res;
                st_d[owner_q]  = alu_st;
                rv_d[owner_q]  = 1'b1;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (own_rdy) begin
                    rv_d[owner_q] = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            rv_q    <= '0;
            res_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            st_q    <= st_d;
        end
    end

    assign rsp0_valid  = rv_q[0];
    assign rsp1_valid  = rv_q[1];
    assign rsp0_result = res_q[0];
    assign rsp1_result = res_q[1];
    assign rsp0_status = st_q[0];
    assign rsp1_status = st_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (round-robin and fixed-priority).
// Inputs change on negedge; outputs are sampled on negedge or #1 after.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_opcode, req1_opcode;
    logic        rsp0_ready, rsp1_ready;

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_status, rsp1_status;

    logic        fp_req0_ready, fp_req1_ready;
    logic        fp_rsp0_valid, fp_rsp1_valid;
    logic [31:0] fp_rsp0_result, fp_rsp1_result;
    logic [3:0]  fp_rsp0_status, fp_rsp1_status;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.RoundRobin(1'b1), .DataWidth(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_opcode(req1_opcode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_status(rsp0_status),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_status(rsp1_status)
    );

    alu_arbiter #(.RoundRobin(1'b0), .DataWidth(32)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_opcode(req1_opcode),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(fp_rsp0_result), .rsp0_status(fp_rsp0_status),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(fp_rsp1_result), .rsp1_status(fp_rsp1_status)
    );

    // Reference add: {N,Z,C,V, result} from plain 33-bit arithmetic.
    function automatic logic [35:0] add_ref(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        return {r[31], r == 32'd0, s[32],
                (a[31] == b[31]) && (r[31] != a[31]), r};
    endfunction

    task automatic idle_inputs();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_a      = '0;
        req0_b      = '0;
        req1_a      = '0;
        req1_b      = '0;
        req0_opcode = '0;
        req1_opcode = '0;
        rsp0_ready  = 1'b1;
        rsp1_ready  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one add from an idle DUT and returns what it observed.
    task automatic issue(input bit who, input logic [31:0] a,
                         input logic [31:0] b, output bit rdy_ok,
                         output bit v_early, output bit v_resp,
                         output logic [31:0] res, output logic [3:0] st,
                         output bit oth_v);
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_opcode = 3'd0;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opcode = 3'd0;
        end
        #1;
        rdy_ok = who ? (req1_ready && !req0_ready)
                     : (req0_ready && !req1_ready);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        v_early = who ? rsp1_valid : rsp0_valid;
        @(negedge clk);
        v_resp = who ? rsp1_valid : rsp0_valid;
        res    = who ? rsp1_result : rsp0_result;
        st     = who ? rsp1_status : rsp0_status;
        oth_v  = who ? rsp0_valid : rsp1_valid;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0000",
                     {req0_ready, req1_ready, fp_req0_ready, fp_req1_ready});
        end
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid});
        end
        checks++;
        if ({rsp0_result, rsp1_result, rsp0_status, rsp1_status} !== 72'd0) begin
            failures++;
            $display("FAIL reset_rsp_data got=%h %h %b %b exp=0",
                     rsp0_result, rsp1_result, rsp0_status, rsp1_status);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_winner got=%b exp=10", {req0_ready, req1_ready});
        end
    endtask

    task automatic test_basic_add();
        bit ok, ve, vr, ov;
        logic [31:0] r;
        logic [3:0] s;
        do_reset();
        issue(1'b0, 32'd0, 32'd0, ok, ve, vr, r, s, ov);
        checks++;
        if (ok !== 1'b1) begin
            failures++; $display("FAIL add0_ready got=%b exp=1", ok);
        end
        checks++;
        if ({ve, vr} !== 2'b01) begin
            failures++; $display("FAIL add0_latency got=%b exp=01", {ve, vr});
        end
        checks++;
        if ({r, s} !== {32'd0, 4'b0100}) begin
            failures++; $display("FAIL add0_value got=%h/%b exp=0/0100", r, s);
        end
        issue(1'b1, 32'hFFFF_FFFF, 32'd0, ok, ve, vr, r, s, ov);
        checks++;
        if ({ok, ve, vr, ov} !== 4'b1010) begin
            failures++;
            $display("FAIL add1_hs got=%b exp=1010", {ok, ve, vr, ov});
        end
        checks++;
        if ({r, s} !== {32'hFFFF_FFFF, 4'b1000}) begin
            failures++; $display("FAIL add1_value got=%h/%b exp=ffffffff/1000", r, s);
        end
    endtask

    task automatic test_round_robin();
        logic [35:0] pend;
        bit pend_who, g, w, got_v;
        logic [31:0] got_r;
        do_reset();
        pend = '0;
        pend_who = 1'b0;
        for (int k = 0; k < 12; k++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            #1;
            g = (k % 3 == 0);
            w = ((k / 3) % 2) == 1;
            checks++;
            if ({req0_ready, req1_ready} !== {g && !w, g && w}) begin
                failures++;
                $display("FAIL rr_grant k=%0d got=%b exp=%b", k,
                         {req0_ready, req1_ready}, {g && !w, g && w});
            end
            if (g) begin
                pend_who = w;
                pend = w ? add_ref(req1_a, req1_b) : add_ref(req0_a, req0_b);
            end
            if (k % 3 == 2) begin
                got_v = pend_who ? rsp1_valid : rsp0_valid;
                got_r = pend_who ? rsp1_result : rsp0_result;
                checks++;
                if ({got_v, got_r} !== {1'b1, pend[31:0]}) begin
                    failures++;
                    $display("FAIL rr_result k=%0d got=%b/%h exp=1/%h",
                             k, got_v, got_r, pend[31:0]);
                end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_fixed_priority();
        logic [35:0] pend;
        bit g;
        do_reset();
        pend = '0;
        for (int k = 0; k < 12; k++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            #1;
            g = (k % 3 == 0);
            checks++;
            if ({fp_req0_ready, fp_req1_ready} !== {g, 1'b0}) begin
                failures++;
                $display("FAIL fp_grant k=%0d got=%b exp=%b", k,
                         {fp_req0_ready, fp_req1_ready}, {g, 1'b0});
            end
            if (g) pend = add_ref(req0_a, req0_b);
            if (k % 3 == 2) begin
                checks++;
                if ({fp_rsp0_valid, fp_rsp1_valid, fp_rsp0_result} !==
                    {2'b10, pend[31:0]}) begin
                    failures++;
                    $display("FAIL fp_result k=%0d got=%b%b/%h exp=10/%h", k,
                             fp_rsp0_valid, fp_rsp1_valid, fp_rsp0_result,
                             pend[31:0]);
                end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Random request patterns against a rule-level arbitration model.
    task automatic test_random_arb();
        bit last, v0, v1, w, e0, e1, f0, f1;
        int busy;
        do_reset();
        last = 1'b1;
        busy = 0;
        for (int k = 0; k < 40; k++) begin
            v0 = 1'($urandom_range(1));
            v1 = 1'($urandom_range(1));
            req0_valid = v0; req1_valid = v1;
            req0_a = $urandom; req1_a = $urandom;
            #1;
            w = (v0 && v1) ? !last : v1;
            e0 = (busy == 0) && v0 && !w;
            e1 = (busy == 0) && v1 && w;
            f0 = (busy == 0) && v0;
            f1 = (busy == 0) && v1 && !v0;
            checks++;
            if ({req0_ready, req1_ready, fp_req0_ready, fp_req1_ready} !==
                {e0, e1, f0, f1}) begin
                failures++;
                $display("FAIL rand_arb k=%0d got=%b exp=%b", k,
                         {req0_ready, req1_ready, fp_req0_ready, fp_req1_ready},
                         {e0, e1, f0, f1});
            end
            if (busy == 0 && (v0 || v1)) begin
                last = w;
                busy = 2;
            end else if (busy > 0) begin
                busy--;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic [35:0] e;
        logic [31:0] a, b;
        do_reset();
        rsp0_ready = 1'b0;
        a = $urandom; b = $urandom;
        e = add_ref(a, b);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opcode = 3'd0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++; $display("FAIL stall_accept got=%b exp=1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = $urandom; req1_a = $urandom;
            #1;
            checks++;
            if ({rsp0_valid, rsp0_result, rsp0_status, req0_ready, req1_ready}
                !== {1'b1, e[31:0], e[35:32], 2'b00}) begin
                failures++;
                $display("FAIL stall_hold i=%0d got=%b/%h/%b/%b%b exp=1/%h/%b/00",
                         i, rsp0_valid, rsp0_result, rsp0_status, req0_ready,
                         req1_ready, e[31:0], e[35:32]);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({rsp0_valid, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL stall_release got=%b exp=01", {rsp0_valid, req1_ready});
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        bit ok, ve, vr, ov;
        bit who;
        logic [31:0] r, a, b;
        logic [3:0] s;
        logic [35:0] e;
        do_reset();
        issue(1'b0, 32'd5, 32'd7, ok, ve, vr, r, s, ov);
        checks++;
        if ({rsp0_valid, rsp0_result} !== {1'b0, 32'd12}) begin
            failures++;
            $display("FAIL keep_last got=%b/%h exp=0/0000000c", rsp0_valid, rsp0_result);
        end
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2;
        @(negedge clk);
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp0_valid, rsp0_result, rsp0_status, req0_ready} !== 38'd0) begin
            failures++;
            $display("FAIL async_reset got=%b/%h/%b/%b exp=0", rsp0_valid,
                     rsp0_result, rsp0_status, req0_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
                failures++;
                $display("FAIL abandoned_rsp i=%0d got=%b exp=00", i,
                         {rsp0_valid, rsp1_valid});
            end
        end
        for (int i = 0; i < 32; i++) begin
            who = (i % 2) == 1;
            a = $urandom; b = $urandom;
            e = add_ref(a, b);
            issue(who, a, b, ok, ve, vr, r, s, ov);
            checks++;
            if ({ok, ve, vr, ov} !== 4'b1010) begin
                failures++;
                $display("FAIL rand_add_hs i=%0d got=%b exp=1010", i, {ok, ve, vr, ov});
            end
            checks++;
            if ({s, r} !== e) begin
                failures++;
                $display("FAIL rand_add i=%0d a=%h b=%h got=%b/%h exp=%b/%h",
                         i, a, b, s, r, e[35:32], e[31:0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_add();
        test_round_robin();
        test_fixed_priority();
        test_random_arb();
        test_stall();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
